sram_port_arbiter: RTL and testbench

- Parametrised N-master arbiter for the single-port SRAM macro.
- Replaces the fixed two-way LOAD_MUX steering between the SRAM loader and the CPU instruction/data path.
- Adds a third master: the pseudo-SPI engine, generalised to NUM_MST.
- Provides registered grants, round-robin or fixed priority, bounded locked bursts, and per-master read-data return.

---
 rtl/sram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// N-master arbiter for the single-port SRAM macro.
// Registered one-hot grant, round-robin or fixed priority, bounded lock bursts.
module sram_port_arbiter #(
    parameter int NUM_MST  = 3,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 8,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_MST-1:0]         REQ,
    input  logic [NUM_MST-1:0]         LOCK,
    input  logic [NUM_MST-1:0]         WE,
    input  logic [NUM_MST*ADDR_W-1:0]  ADDR,
    input  logic [NUM_MST*DATA_W-1:0]  WDATA,
    output logic [NUM_MST-1:0]         GNT,
    output logic [NUM_MST-1:0]         RVALID,
    output logic [DATA_W-1:0]          RDATA,
    output logic                       CEN,
    output logic                       WEN,
    output logic [ADDR_W-1:0]          A,
    output logic [DATA_W-1:0]          D,
    input  logic [DATA_W-1:0]          Q
);

    localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]         state;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      win;
    logic [HW-1:0]      hold_cnt;
    logic [NUM_MST-1:0] gnt_q;
    logic [NUM_MST-1:0] rvalid_q;
    logic [NUM_MST-1:0] cand;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  d_q;
    logic [ADDR_W-1:0]  a_q;
    logic [ADDR_W-1:0]  addr_a  [NUM_MST];
    logic [DATA_W-1:0]  wdata_a [NUM_MST];
    logic               acc;
    logic               sel_we;
    logic               locked;
    logic               hold;
    logic               expired;
    logic               others;
    logic               found;

    always_comb begin
        for (int m = 0; m < NUM_MST; m++) begin
            addr_a[m]  = ADDR[m*ADDR_W +: ADDR_W];
            wdata_a[m] = WDATA[m*DATA_W +: DATA_W];
        end
    end

    // gnt_q is one-hot, so masking with it selects the owner's bits
    assign acc     = |(REQ & gnt_q);
    assign sel_we  = |(WE & gnt_q);
    assign locked  = |(REQ & LOCK & gnt_q);
    assign hold    = locked && (hold_cnt < HW'(MAX_HOLD - 1));
    assign expired = locked && !hold;
    assign others  = |(REQ & ~gnt_q);
    assign cand    = (expired && others) ? (REQ & ~gnt_q) : REQ;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        if (RR_EN != 0) begin
            for (int k = 1; k <= NUM_MST; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_MST;
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    win   = IW'(idx);
                end
            end
        end else begin
            for (int k = NUM_MST - 1; k >= 0; k--) begin
                if (cand[k]) begin
                    found = 1'b1;
                    win   = IW'(k);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= IW'(NUM_MST - 1);
            hold_cnt <= '0;
            gnt_q    <= '0;
        end else if (hold) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else if (found) begin
            state    <= ST_OWNED;
            owner    <= win;
            rr_ptr   <= win;
            hold_cnt <= '0;
            gnt_q    <= NUM_MST'(1) << win;
        end else begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            gnt_q    <= '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            a_q      <= '0;
            d_q      <= '0;
        end else begin
            rvalid_q <= (acc && !sel_we) ? gnt_q : '0;
            if (|rvalid_q)
                rdata_q <= Q;
            if (acc) begin
                a_q <= addr_a[owner];
                d_q <= wdata_a[owner];
            end
        end
    end

    // A withdrawn owner leaves the port idle but keeps A/D stable
    assign GNT    = (state == ST_OWNED) ? gnt_q : '0;
    assign RVALID = rvalid_q;
    assign RDATA  = (|rvalid_q) ? Q : rdata_q;
    assign CEN    = ~acc;
    assign WEN    = ~(acc && sel_we);
    assign A      = acc ? addr_a[owner] : a_q;
    assign D      = acc ? wdata_a[owner] : d_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised bench for sram_port_arbiter: one round-robin and one fixed-priority
// instance share stimulus and are compared against a per-instance reference model.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  we;
    logic [26:0] addr;
    logic [23:0] wdata;

    logic [2:0]  gnt    [2];
    logic [2:0]  rvalid [2];
    logic [7:0]  rdata  [2];
    logic        cen    [2];
    logic        wen    [2];
    logic [8:0]  a      [2];
    logic [7:0]  d_o    [2];
    logic [7:0]  q      [2];

    logic [7:0]  sram0 [512];
    logic [7:0]  sram1 [512];

    int          own_m  [2];
    int          hc_m   [2];
    int          ptr_m  [2];
    int          rv_m   [2];
    logic [7:0]  held_m [2];
    logic [7:0]  pend_m [2];
    logic [7:0]  ld_m   [2];
    logic [8:0]  la_m   [2];
    logic [7:0]  mm     [2][512];

    int n_vec;
    int n_err;

    localparam int MH = 4;

    sram_port_arbiter #(
        .NUM_MST(3), .ADDR_W(9), .DATA_W(8), .RR_EN(1), .MAX_HOLD(MH)
    ) u_rr (
        .CLK(clk), .RST(rst), .REQ(req), .LOCK(lock), .WE(we),
        .ADDR(addr), .WDATA(wdata), .GNT(gnt[0]), .RVALID(rvalid[0]),
        .RDATA(rdata[0]), .CEN(cen[0]), .WEN(wen[0]), .A(a[0]),
        .D(d_o[0]), .Q(q[0])
    );

    sram_port_arbiter #(
        .NUM_MST(3), .ADDR_W(9), .DATA_W(8), .RR_EN(0), .MAX_HOLD(MH)
    ) u_fx (
        .CLK(clk), .RST(rst), .REQ(req), .LOCK(lock), .WE(we),
        .ADDR(addr), .WDATA(wdata), .GNT(gnt[1]), .RVALID(rvalid[1]),
        .RDATA(rdata[1]), .CEN(cen[1]), .WEN(wen[1]), .A(a[1]),
        .D(d_o[1]), .Q(q[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous SRAM macros: Q valid the cycle after a read
    always @(posedge clk) begin
        if (!cen[0]) begin
            if (!wen[0]) sram0[a[0]] <= d_o[0];
            else         q[0] <= sram0[a[0]];
        end
    end

    always @(posedge clk) begin
        if (!cen[1]) begin
            if (!wen[1]) sram1[a[1]] <= d_o[1];
            else         q[1] <= sram1[a[1]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own_m[k]  = -1;
            hc_m[k]   = 0;
            ptr_m[k]  = 2;
            rv_m[k]   = -1;
            held_m[k] = 8'h00;
            la_m[k]   = 9'h000;
            ld_m[k]   = 8'h00;
        end
    endtask

    task automatic mchk(input int k);
        int o;
        bit acc;
        logic [8:0] ea;
        logic [7:0] ed;
        logic exp_wen;
        o = own_m[k];
        acc = 1'b0;
        ea = la_m[k];
        ed = ld_m[k];
        exp_wen = 1'b1;
        if (o >= 0) begin
            if (req[o]) begin
                acc = 1'b1;
                ea = addr[o*9 +: 9];
                ed = wdata[o*8 +: 8];
                exp_wen = ~we[o];
            end
        end
        if (rv_m[k] >= 0)
            held_m[k] = pend_m[k];
        chk($sformatf("dut%0d gnt", k), 32'(gnt[k]), (o >= 0) ? (1 << o) : 0);
        chk($sformatf("dut%0d cen", k), 32'(cen[k]), 32'(!acc));
        chk($sformatf("dut%0d wen", k), 32'(wen[k]), 32'(exp_wen));
        chk($sformatf("dut%0d addr", k), 32'(a[k]), 32'(ea));
        chk($sformatf("dut%0d wdata", k), 32'(d_o[k]), 32'(ed));
        chk($sformatf("dut%0d rvalid", k), 32'(rvalid[k]),
            (rv_m[k] >= 0) ? (1 << rv_m[k]) : 0);
        chk($sformatf("dut%0d rdata", k), 32'(rdata[k]), 32'(held_m[k]));
    endtask

    task automatic mstep(input int k);
        int o;
        int w;
        int c;
        bit expired;
        logic [8:0] ea;
        o = own_m[k];
        rv_m[k] = -1;
        if (o >= 0) begin
            if (req[o]) begin
                ea = addr[o*9 +: 9];
                la_m[k] = ea;
                ld_m[k] = wdata[o*8 +: 8];
                if (we[o]) begin
                    mm[k][ea] = wdata[o*8 +: 8];
                end else begin
                    rv_m[k] = o;
                    pend_m[k] = mm[k][ea];
                end
            end
        end
        if (o >= 0 && req[o] && lock[o] && hc_m[k] < MH - 1) begin
            hc_m[k]++;
        end else begin
            expired = (o >= 0) && req[o] && lock[o];
            hc_m[k] = 0;
            w = -1;
            for (int j = 1; j <= 3; j++) begin
                c = (k == 0) ? (ptr_m[k] + j) % 3 : j - 1;
                if (w < 0 && req[c]) begin
                    if (!(expired && c == o && (req & ~(3'b1 << o)) != 3'b0))
                        w = c;
                end
            end
            own_m[k] = w;
            if (w >= 0) ptr_m[k] = w;
        end
    endtask

    task automatic reset_seq();
        #1;
        rst  = 1'b1;
        req  = 3'b000;
        lock = 3'b000;
        we   = 3'b000;
        model_reset();
        #1;
        mchk(0);
        mchk(1);
        @(negedge clk);
        #1;
        mchk(0);
        mchk(1);
        rst = 1'b0;
    endtask

    task automatic cyc(input logic [2:0] r, input logic [2:0] l,
                       input logic [2:0] w, input logic [26:0] ad,
                       input logic [23:0] wd, input bit rs);
        @(negedge clk);
        req   = r;
        lock  = l;
        we    = w;
        addr  = ad;
        wdata = wd;
        #1;
        mchk(0);
        mchk(1);
        if (rs) begin
            reset_seq();
        end else begin
            mstep(0);
            mstep(1);
        end
    endtask

    function automatic logic [26:0] rnd_addr();
        logic [26:0] v;
        for (int m = 0; m < 3; m++)
            v[m*9 +: 9] = 9'($urandom_range(0, 31));
        return v;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 3'b000;
        lock  = 3'b000;
        we    = 3'b000;
        addr  = '0;
        wdata = '0;
        q[0]  = 8'h00;
        q[1]  = 8'h00;
        for (int i = 0; i < 512; i++) begin
            sram0[i] = 8'(i * 7 + 3);
            sram1[i] = 8'(i * 7 + 3);
            mm[0][i] = 8'(i * 7 + 3);
            mm[1][i] = 8'(i * 7 + 3);
        end
        sram0[9'h123] = 8'h5C;
        sram1[9'h123] = 8'h5C;
        mm[0][9'h123] = 8'h5C;
        mm[1][9'h123] = 8'h5C;
        reset_seq();

        // single read by master 1
        repeat (2) cyc(3'b010, 3'b000, 3'b000, {9'd0, 9'h123, 9'd0}, 24'h0, 0);
        repeat (2) cyc(3'b000, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);

        // all masters request, no lock
        repeat (7) cyc(3'b111, 3'b000, 3'b000, rnd_addr(), 24'($urandom), 0);
        repeat (2) cyc(3'b000, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);

        // master 2 locked write burst, master 0 requests from cycle 2 to 5
        for (int i = 0; i < 10; i++)
            cyc(3'b100 | ((i >= 2 && i <= 5) ? 3'b001 : 3'b000), 3'b100,
                3'b100, {9'(9'h40 + i), 9'd0, 9'h11}, {8'(8'hA0 + i), 16'h0}, 0);
        repeat (2) cyc(3'b000, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);

        // masters 1 and 2, then master 0 joins
        repeat (4) cyc(3'b110, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);
        repeat (4) cyc(3'b111, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);
        repeat (2) cyc(3'b000, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);

        // withdrawn request
        cyc(3'b010, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);
        cyc(3'b100, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);
        cyc(3'b100, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);
        repeat (2) cyc(3'b000, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);

        // reset while master 1 read is being accepted
        cyc(3'b010, 3'b000, 3'b000, {9'd0, 9'h0A5, 9'd0}, 24'h0, 0);
        cyc(3'b010, 3'b000, 3'b000, {9'd0, 9'h0A5, 9'd0}, 24'h0, 1);
        repeat (3) cyc(3'b000, 3'b000, 3'b000, rnd_addr(), 24'h0, 0);

        for (int i = 0; i < 3000; i++)
            cyc(3'($urandom), 3'($urandom), 3'($urandom), rnd_addr(),
                24'($urandom), $urandom_range(0, 299) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
